// File: rtl/output_capture_pkg.sv
// ============================================================================
// Module   : output_capture_pkg
// Purpose  : Shared defaults and FSM state encoding for output_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package output_capture_pkg;

  localparam int unsigned C_WIDTH = 16;
  localparam int unsigned C_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Purpose  : Synchronous FIFO with registered storage, pointers and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync
  import output_capture_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int DEPTH = C_DEPTH
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == C_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_capture.sv
// ============================================================================
// Module   : output_capture
// Purpose  : Captures processor output words into a FIFO, drains after halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_capture
  import output_capture_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int DEPTH = C_DEPTH
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         bus,
  input  logic                     bus_enable,
  input  logic                     halt,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              total,
  output logic                     overflow,
  output logic                     done
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_total;
  logic        r_overflow;
  logic        w_full;
  logic        w_empty;
  logic        w_run;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (bus),
    .rdata  (out_data),
    .full   (w_full),
    .empty  (w_empty),
    .count  (count)
  );

  assign w_run     = (r_state == ST_RUN);
  assign out_valid = !w_empty && (r_state != ST_DONE);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = bus_enable && w_run && (!w_full || w_pop);
  assign w_drop    = bus_enable && w_run && w_full && !w_pop;
  assign total     = r_total;
  assign overflow  = r_overflow;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= ST_RUN;
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_total <= r_total + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    done         = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

endmodule

`default_nettype wire
